// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor.
// Operands are cut into STAGES slices of SW = WIDTH/STAGES bits. Each stage
// resolves one slice, and the carry ripples from stage to stage. The untouched
// upper operand slices travel with the beat. The finished lower result slices
// also travel with it, so every slice of the result leaves the pipe together.
// The output side uses valid/ready. A stalled output freezes the whole pipe.
// Optional build macro ADDSUB_SAT_EN: on signed overflow, sum clamps to the
// signed limit on the side of A's sign. carry and overflow still report the
// unsaturated result.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registers. b_r holds effective B (already inverted for subtract),
  // so sel needs no separate alignment register.
  logic             vld   [STAGES];
  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  logic [WIDTH-1:0] s_r   [STAGES];
  logic             c_r   [STAGES];

  logic             v_src [STAGES];
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src [STAGES];

  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             c_nxt [STAGES];

  logic             stall;
  logic             ovf_raw;

  assign out_valid = vld[LAST];
  assign stall     = vld[LAST] && !out_ready;
  assign in_ready  = !stall;

  // Stage inputs: stage 0 takes the operands, later stages take the previous stage
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_src[k] = 1'b0;
      a_src[k] = '0;
      b_src[k] = '0;
      s_src[k] = '0;
      c_src[k] = 1'b0;
    end
    v_src[0] = in_valid;
    a_src[0] = a;
    b_src[0] = sel ? ~b : b;
    s_src[0] = '0;
    c_src[0] = sel;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = vld[k-1];
      a_src[k] = a_r[k-1];
      b_src[k] = b_r[k-1];
      s_src[k] = s_r[k-1];
      c_src[k] = c_r[k-1];
    end
  end

  // Slice adders: stage k resolves slice k and keeps the lower slices done so far
  always_comb begin
    logic [SW:0] part;
    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      s_nxt[k] = '0;
      c_nxt[k] = 1'b0;
    end
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_src[k][k*SW +: SW]} + {1'b0, b_src[k][k*SW +: SW]}
           + {{SW{1'b0}}, c_src[k]};
      s_nxt[k] = s_src[k];
      s_nxt[k][k*SW +: SW] = part[SW-1:0];
      c_nxt[k] = part[SW];
    end
  end

  // Pipeline registers: every stage advances together unless the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k] <= v_src[k];
        a_r[k] <= a_src[k];
        b_r[k] <= b_src[k];
        s_r[k] <= s_nxt[k];
        c_r[k] <= c_nxt[k];
      end
    end
  end

  // The sign-based overflow flag works on effective B, so one form serves both add and sub
  assign ovf_raw  = (a_r[LAST][WIDTH-1] == b_r[LAST][WIDTH-1]) &&
                    (s_r[LAST][WIDTH-1] != a_r[LAST][WIDTH-1]);
  assign overflow = ovf_raw;
  assign carry    = c_r[LAST];

`ifdef ADDSUB_SAT_EN
  assign sum = !ovf_raw ? s_r[LAST] :
               (a_r[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign sum = s_r[LAST];
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: self-checking bench for addsub_pipe.
// It checks two instances: a 16-bit, 4-stage pipe and a 4-bit, single-stage pipe.
// Results are checked against an integer-arithmetic reference model.
module tb_addsub_pipe;

  localparam int W = 16;
  localparam int S = 4;

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] EXP_MAXPLUS1 = 16'h7FFF;
  localparam logic [3:0]  EXP4_FIRST   = 4'h8;
`else
  localparam logic [15:0] EXP_MAXPLUS1 = 16'h8000;
  localparam logic [3:0]  EXP4_FIRST   = 4'h3;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, sel, out_valid, out_ready, carry, overflow;
  logic [W-1:0]  a, b, sum;

  logic          in_valid4, in_ready4, sel4, out_valid4, out_ready4, carry4, overflow4;
  logic [3:0]    a4, b4, sum4;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow)
  );

  addsub_pipe #(.WIDTH(4), .STAGES(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .sel(sel4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .carry(carry4), .overflow(overflow4)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int pops = 0;

  typedef struct {
    logic [17:0] e;
    int          c;
    int          s;
  } beat_t;
  beat_t q[$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_sum;
  logic        prev_c, prev_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on w-bit values; returns {ovf, carry, sum}
  function automatic logic [17:0] model(input int w, input logic [15:0] av,
                                        input logic [15:0] bv, input logic s);
    longint m, ua, ub, sa, sb, r, t;
    logic   c, o;
    m  = longint'(1) << w;
    ua = longint'(av);
    ub = longint'(bv);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = s ? sa - sb : sa + sb;
    o  = (r >= m / 2) || (r < -(m / 2));
    c  = s ? (ua >= ub) : (ua + ub >= m);
    t  = (s ? ua - ub + m : ua + ub) % m;
`ifdef ADDSUB_SAT_EN
    if (o) t = (sa < 0) ? m / 2 : m / 2 - 1;
`endif
    return {o, c, 16'(t)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: enqueue accepted beats, check every delivered result, in_ready and stall hold
  always @(negedge clk) begin : mon
    beat_t bt;
    if (rst_n) begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall && out_valid) begin
        chk("hold_sum", sum, prev_sum);
        chk("hold_carry", carry, prev_c);
        chk("hold_overflow", overflow, prev_o);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: out_valid=1 sum=%0h with no beat outstanding", sum);
        end else begin
          bt = q.pop_front();
          pops++;
          chk("sum", sum, bt.e[15:0]);
          chk("carry", carry, bt.e[16]);
          chk("overflow", overflow, bt.e[17]);
          chk("latency", cyc, bt.c + S + (stall_cnt - bt.s));
        end
      end
      if (in_valid && in_ready) begin
        bt.e = model(W, a, b, sel);
        bt.c = cyc;
        bt.s = stall_cnt;
        q.push_back(bt);
      end
      if (out_valid && !out_ready) stall_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_c     = carry;
      prev_o     = overflow;
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic s);
    logic acc;
    acc = 1'b0;
    a = av;
    b = bv;
    sel = s;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for 100 cycles, expected 1");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_outstanding", q.size(), 0);
  endtask

  // Exact latency: beat driven in cycle 0 must be absent after 3 edges and present after 4
  task automatic lat_vec(input logic [15:0] av, input logic [15:0] bv, input logic s,
                         input logic [15:0] es, input logic ec, input logic eo);
    a = av;
    b = bv;
    sel = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("lat_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_sum", sum, es);
    chk("lat_carry", carry, ec);
    chk("lat_overflow", overflow, eo);
  endtask

  task automatic vec4(input logic [3:0] av, input logic [3:0] bv, input logic s,
                      input logic [3:0] es, input logic ec, input logic eo);
    a4 = av;
    b4 = bv;
    sel4 = s;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    chk("w4_valid", out_valid4, 1'b1);
    chk("w4_sum", sum4, es);
    chk("w4_carry", carry4, ec);
    chk("w4_overflow", overflow4, eo);
    @(posedge clk);
    #1;
    chk("w4_bubble", out_valid4, 1'b0);
  endtask

  logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic obs [12];
  int   p0;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sel = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sel4 = 1'b0; out_ready4 = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 16'h0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_carry", carry, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_w4_valid", out_valid4, 1'b0);

    // Pin the reference model with hand-computed values
    chk("model_4b_sub", model(4, 16'h8, 16'h5, 1'b1), {1'b1, 1'b1, 12'h0, EXP4_FIRST});
    chk("model_16b_wrap", model(16, 16'hFFFF, 16'h0001, 1'b0), {2'b01, 16'h0000});
    chk("model_16b_borrow", model(16, 16'h0000, 16'h0001, 1'b1), {2'b00, 16'hFFFF});

    // 4-bit, single-stage instance
    vec4(4'b1000, 4'b0101, 1'b1, EXP4_FIRST, 1'b1, 1'b1);
    vec4(4'b1111, 4'b1000, 1'b1, 4'b0111, 1'b1, 1'b0);
    vec4(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // 16-bit, 4-stage directed vectors with exact latency
    lat_vec(16'h7FFF, 16'h0001, 1'b0, EXP_MAXPLUS1, 1'b0, 1'b1);
    lat_vec(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    lat_vec(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    drain();

    // Back-to-back random stream
    p0 = pops;
    for (int i = 0; i < 20; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom));
    drain();
    chk("stream_count", pops - p0, 20);

    // Stall mid-stream
    p0 = pops;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(16'($urandom), 16'($urandom), 1'($urandom));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_out_valid", out_valid, 1'b1);
        chk("stall_in_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", pops - p0, 6);

    // Bubbles: in_valid 1,0,1,0 must reappear on out_valid four cycles later
    for (int j = 0; j < 10; j++) begin
      if (j < 4) begin
        in_valid = pat[j];
        a = 16'($urandom);
        b = 16'($urandom);
        sel = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      obs[j+1] = out_valid;
    end
    for (int i = 0; i < 4; i++) chk("bubble_pattern", obs[i+4], pat[i]);
    drain();

    // Asynchronous reset with three beats in flight
    send(16'h1234, 16'h4321, 1'b0);
    send(16'h8000, 16'h0001, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    prev_stall = 1'b0;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_sum", sum, 16'h0);
    chk("async_rst_carry", carry, 1'b0);
    chk("async_rst_overflow", overflow, 1'b0);
    #4 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_result", out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
